// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences PC/IR, ALU,
// register file and the unified memory port over 3-5+ cycles per instruction.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       fault,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        FAULT  = 4'd9
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_next;
    logic             timeout;
    logic             mem_state;

    assign state_dbg = state;
    assign timeout   = (wait_cnt == WAIT_LAST) && !mem_ready;
    assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Strobes are gated by reset so an in-flight write is dropped immediately,
    // not at the next clock edge.
    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        retire        = 1'b0;
        fault         = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end else if (timeout) begin
                        state_next = FAULT;
                    end
                end
                DECODE: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_R:         state_next = EXEC;
                        OP_BEQ:       state_next = BRANCH;
                        default:      state_next = FAULT;
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    if (opcode == OP_LW)      state_next = MEMRD;
                    else if (opcode == OP_SW) state_next = MEMWR;
                    else                      state_next = FAULT;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready)    state_next = MEMWB;
                    else if (timeout) state_next = FAULT;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    state_next = FETCH;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else if (timeout) begin
                        state_next = FAULT;
                    end
                end
                EXEC: begin
                    alu_src_a  = 2'b01;
                    alu_op     = 2'b10;
                    state_next = RWB;
                end
                RWB: begin
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    state_next = FETCH;
                end
                BRANCH: begin
                    alu_src_a     = 2'b01;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                    retire        = 1'b1;
                    state_next    = FETCH;
                end
                FAULT:   fault      = 1'b1;
                default: state_next = FAULT;
            endcase
        end
    end

    // Counter restarts on every state change, including FETCH re-entry after retire.
    always_comb begin
        wait_next = wait_cnt;
        if (state_next != state)
            wait_next = '0;
        else if (mem_state && !mem_ready)
            wait_next = wait_cnt + 1'b1;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and packed strobe
// vector compared against hand-computed constants.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, retire, fault;
    logic [3:0] state_dbg;

    int tests = 0;
    int fails = 0;

    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
        .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_we,iord,ir_write,pc_write,pc_write_cond,pc_source,a,b,op,reg_write,mem_to_reg,retire,fault}
    logic [16:0] obs;
    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, retire, fault};

    localparam logic [16:0] V_FETCH_R = 17'b1_0_0_1_1_0_0_00_01_00_0_0_0_0;
    localparam logic [16:0] V_FETCH_N = 17'b1_0_0_0_0_0_0_00_01_00_0_0_0_0;
    localparam logic [16:0] V_DECODE  = 17'b0_0_0_0_0_0_0_10_10_00_0_0_0_0;
    localparam logic [16:0] V_MEMADR  = 17'b0_0_0_0_0_0_0_01_10_00_0_0_0_0;
    localparam logic [16:0] V_MEMRD   = 17'b1_0_1_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [16:0] V_MEMWB   = 17'b0_0_0_0_0_0_0_00_00_00_1_1_1_0;
    localparam logic [16:0] V_MEMWR_R = 17'b1_1_1_0_0_0_0_00_00_00_0_0_1_0;
    localparam logic [16:0] V_MEMWR_N = 17'b1_1_1_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [16:0] V_EXEC    = 17'b0_0_0_0_0_0_0_01_00_10_0_0_0_0;
    localparam logic [16:0] V_RWB     = 17'b0_0_0_0_0_0_0_00_00_00_1_0_1_0;
    localparam logic [16:0] V_BRANCH  = 17'b0_0_0_0_0_1_1_01_00_01_0_0_1_0;
    localparam logic [16:0] V_FAULT   = 17'b0_0_0_0_0_0_0_00_00_00_0_0_0_1;
    localparam logic [16:0] V_ZERO    = 17'b0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) next_cycle();
        tests++;
        if ({state_dbg, obs} !== {4'd0, V_ZERO}) begin
            fails++;
            $display("FAIL reset_hold: state=%0d vec=%b, want state=0 vec=%b", state_dbg, obs, V_ZERO);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_rtype();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic [16:0] ev [5] = '{V_FETCH_R, V_DECODE, V_EXEC, V_RWB, V_FETCH_R};
        opcode = 7'b0110011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({state_dbg, obs} !== {es[i], ev[i]}) begin
                fails++;
                $display("FAIL rtype c%0d: state=%0d vec=%b, want state=%0d vec=%b", i + 1, state_dbg, obs, es[i], ev[i]);
            end
            if (i < 4) next_cycle();
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  es  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [16:0] ev  [8] = '{V_FETCH_R, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            tests++;
            if ({state_dbg, obs} !== {es[i], ev[i]}) begin
                fails++;
                $display("FAIL lw_wait c%0d: state=%0d vec=%b, want state=%0d vec=%b", i + 1, state_dbg, obs, es[i], ev[i]);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_branch();
        logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd8};
        logic [16:0] ev [3] = '{V_FETCH_R, V_DECODE, V_BRANCH};
        opcode = 7'b1100011; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            for (int i = 0; i < 3; i++) begin
                #1;
                tests++;
                if ({state_dbg, obs} !== {es[i], ev[i]}) begin
                    fails++;
                    $display("FAIL beq_z%0d c%0d: state=%0d vec=%b, want state=%0d vec=%b", zero, i + 1, state_dbg, obs, es[i], ev[i]);
                end
                next_cycle();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        opcode = 7'b0010011; mem_ready = 1'b1;
        next_cycle();
        tests++;
        if ({state_dbg, obs} !== {4'd1, V_DECODE}) begin
            fails++;
            $display("FAIL illegal_decode: state=%0d vec=%b, want state=1 vec=%b", state_dbg, obs, V_DECODE);
        end
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            zero = i[1];
            #1;
            tests++;
            if ({state_dbg, obs} !== {4'd9, V_FAULT}) begin
                fails++;
                $display("FAIL fault_hold c%0d: state=%0d vec=%b, want state=9 vec=%b", i, state_dbg, obs, V_FAULT);
            end
            next_cycle();
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({state_dbg, fault} !== {4'd0, 1'b0}) begin
            fails++;
            $display("FAIL fault_clear: state=%0d fault=%b, want state=0 fault=0", state_dbg, fault);
        end
        next_cycle();
        reset = 1'b0;
        zero = 1'b0;
    endtask

    task automatic test_fetch_timeout();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if ({state_dbg, obs} !== {4'd0, V_FETCH_N}) begin
                fails++;
                $display("FAIL fetch_wait c%0d: state=%0d vec=%b, want state=0 vec=%b", i + 1, state_dbg, obs, V_FETCH_N);
            end
            next_cycle();
        end
        tests++;
        if ({state_dbg, obs} !== {4'd9, V_FAULT}) begin
            fails++;
            $display("FAIL fetch_timeout: state=%0d vec=%b, want state=9 vec=%b", state_dbg, obs, V_FAULT);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        // 15 idle cycles, then ready arrives in the last allowed cycle
        for (int i = 0; i < 15; i++) next_cycle();
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        #1;
        tests++;
        if ({state_dbg, obs} !== {4'd0, V_FETCH_R}) begin
            fails++;
            $display("FAIL fetch_last_ready: state=%0d vec=%b, want state=0 vec=%b", state_dbg, obs, V_FETCH_R);
        end
        next_cycle();
        tests++;
        if ({state_dbg, fault} !== {4'd1, 1'b0}) begin
            fails++;
            $display("FAIL fetch_no_fault: state=%0d fault=%b, want state=1 fault=0", state_dbg, fault);
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_store_reset();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        logic [16:0] ev [5] = '{V_FETCH_R, V_DECODE, V_MEMADR, V_MEMWR_R, V_FETCH_R};
        opcode = 7'b0100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({state_dbg, obs} !== {es[i], ev[i]}) begin
                fails++;
                $display("FAIL sw c%0d: state=%0d vec=%b, want state=%0d vec=%b", i + 1, state_dbg, obs, es[i], ev[i]);
            end
            if (i < 4) next_cycle();
        end
        repeat (3) next_cycle();
        mem_ready = 1'b0;
        #1;
        tests++;
        if ({state_dbg, obs} !== {4'd5, V_MEMWR_N}) begin
            fails++;
            $display("FAIL sw_pending: state=%0d vec=%b, want state=5 vec=%b", state_dbg, obs, V_MEMWR_N);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({state_dbg, mem_req, mem_we} !== {4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sw_reset_drop: state=%0d req=%b we=%b, want state=0 req=0 we=0", state_dbg, mem_req, mem_we);
        end
        next_cycle();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        tests++;
        if ({state_dbg, obs} !== {4'd0, V_FETCH_R}) begin
            fails++;
            $display("FAIL sw_after_reset: state=%0d vec=%b, want state=0 vec=%b", state_dbg, obs, V_FETCH_R);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_fetch_timeout();
        test_store_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
